// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one data RAM between the CPU load/store port and a DMA/loader port.
// A granted request is latched and driven to the RAM for LATENCY cycles. The read data
// then comes back to the owning port with a one-cycle rvalid pulse.
// Build option: define RAM_ARB_RR_EN to break ties round-robin. Without it, ties are
// fixed-priority with the CPU winning.
module ram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MODE_W  = 4,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [MODE_W-1:0] cpu_mode,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic [MODE_W-1:0] dma_mode,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [MODE_W-1:0] ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              owner_dma, owner_dma_nxt;
    logic [MODE_W-1:0] sel_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              cpu_gnt_nxt, dma_gnt_nxt;
    logic              cpu_rvalid_nxt, dma_rvalid_nxt;
    logic [DATA_W-1:0] cpu_rdata_nxt, dma_rdata_nxt;
    logic              cpu_valid, dma_valid, pick_dma;

    assign cpu_valid = cpu_req && (cpu_mode != '0);
    assign dma_valid = dma_req && (dma_mode != '0);

`ifdef RAM_ARB_RR_EN
    // Tracks which port won the most recent grant. It resets to DMA so that the CPU
    // wins the first tie.
    logic last_dma, last_dma_nxt;

    // On a tie, the port that did not win last time goes first.
    always_comb begin
        pick_dma     = dma_valid && (!cpu_valid || !last_dma);
        last_dma_nxt = last_dma;
        if (state == IDLE && (cpu_valid || dma_valid))
            last_dma_nxt = pick_dma;
    end

    // Round-robin history register
    always_ff @(posedge clk) begin
        if (rst) last_dma <= 1'b1;
        else     last_dma <= last_dma_nxt;
    end
`else
    // Fixed priority: the DMA only wins when the CPU is not asking.
    always_comb begin
        pick_dma = dma_valid && !cpu_valid;
    end
`endif

    // Next-state logic. The rdata and rvalid registers are loaded on the last BUSY edge,
    // so both are visible together during RESP.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        owner_dma_nxt  = owner_dma;
        sel_nxt        = ram_sel;
        addr_nxt       = ram_addr;
        wdata_nxt      = ram_wdata;
        cpu_gnt_nxt    = 1'b0;
        dma_gnt_nxt    = 1'b0;
        cpu_rvalid_nxt = 1'b0;
        dma_rvalid_nxt = 1'b0;
        cpu_rdata_nxt  = cpu_rdata;
        dma_rdata_nxt  = dma_rdata;
        case (state)
            IDLE: begin
                if (cpu_valid || dma_valid) begin
                    state_nxt     = BUSY;
                    cnt_nxt       = CNT_W'(LATENCY);
                    owner_dma_nxt = pick_dma;
                    if (pick_dma) begin
                        dma_gnt_nxt = 1'b1;
                        sel_nxt     = dma_mode;
                        addr_nxt    = dma_addr;
                        wdata_nxt   = dma_wdata;
                    end else begin
                        cpu_gnt_nxt = 1'b1;
                        sel_nxt     = cpu_mode;
                        addr_nxt    = cpu_addr;
                        wdata_nxt   = cpu_wdata;
                    end
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                    sel_nxt   = '0;
                    if (owner_dma) begin
                        dma_rvalid_nxt = 1'b1;
                        dma_rdata_nxt  = ram_rdata;
                    end else begin
                        cpu_rvalid_nxt = 1'b1;
                        cpu_rdata_nxt  = ram_rdata;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
        endcase
    end

    // State and output registers. A reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_dma  <= 1'b0;
            ram_sel    <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            owner_dma  <= owner_dma_nxt;
            ram_sel    <= sel_nxt;
            ram_addr   <= addr_nxt;
            ram_wdata  <= wdata_nxt;
            cpu_gnt    <= cpu_gnt_nxt;
            dma_gnt    <= dma_gnt_nxt;
            cpu_rvalid <= cpu_rvalid_nxt;
            dma_rvalid <= dma_rvalid_nxt;
            cpu_rdata  <= cpu_rdata_nxt;
            dma_rdata  <= dma_rdata_nxt;
        end
    end

    assign busy      = (state != IDLE);
    assign cpu_stall = cpu_req & ~cpu_rvalid;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter. Two instances (LATENCY 1 and 3) are checked every cycle
// against a transaction-level model that tracks cycles since the grant.
module tb_ram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst[2];
    logic          cpu_req[2], dma_req[2];
    logic [MW-1:0] cpu_mode[2], dma_mode[2];
    logic [AW-1:0] cpu_addr[2], dma_addr[2];
    logic [DW-1:0] cpu_wdata[2], dma_wdata[2], ram_rdata[2];
    logic          cpu_gnt[2], dma_gnt[2], cpu_rvalid[2], dma_rvalid[2], cpu_stall[2], busy[2];
    logic [DW-1:0] cpu_rdata[2], dma_rdata[2], ram_wdata[2];
    logic [AW-1:0] ram_addr[2];
    logic [MW-1:0] ram_sel[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MODE_W(MW), .LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst[g]),
            .cpu_req(cpu_req[g]), .cpu_mode(cpu_mode[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_gnt(cpu_gnt[g]), .cpu_rvalid(cpu_rvalid[g]),
            .cpu_rdata(cpu_rdata[g]), .cpu_stall(cpu_stall[g]),
            .dma_req(dma_req[g]), .dma_mode(dma_mode[g]), .dma_addr(dma_addr[g]),
            .dma_wdata(dma_wdata[g]), .dma_gnt(dma_gnt[g]), .dma_rvalid(dma_rvalid[g]),
            .dma_rdata(dma_rdata[g]),
            .ram_sel(ram_sel[g]), .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]),
            .ram_rdata(ram_rdata[g]), .busy(busy[g])
        );
    end

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Model: age 0 = idle, 1..L = RAM cycles after the grant, L+1 = response cycle.
    int            m_age[2];
    bit            m_last_dma[2];
    logic [MW-1:0] m_mode[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wdata[2];
    bit            m_owner_dma[2];
    logic          e_cpu_gnt[2], e_dma_gnt[2], e_cpu_rvalid[2], e_dma_rvalid[2];
    logic [DW-1:0] e_cpu_rdata[2], e_dma_rdata[2];

    function automatic void model_step(int k);
        bit cv, dv, d;
        e_cpu_gnt[k] = 1'b0; e_dma_gnt[k] = 1'b0;
        e_cpu_rvalid[k] = 1'b0; e_dma_rvalid[k] = 1'b0;
        if (rst[k]) begin
            m_age[k] = 0; m_mode[k] = '0; m_addr[k] = '0; m_wdata[k] = '0;
            e_cpu_rdata[k] = '0; e_dma_rdata[k] = '0; m_last_dma[k] = 1'b1;
            return;
        end
        if (m_age[k] == 0) begin
            cv = cpu_req[k] && (cpu_mode[k] != 0);
            dv = dma_req[k] && (dma_mode[k] != 0);
            if (cv || dv) begin
                if (cv && dv) d = RR ? !m_last_dma[k] : 1'b0;
                else          d = dv;
                m_owner_dma[k] = d;
                m_last_dma[k]  = d;
                m_mode[k]  = d ? dma_mode[k]  : cpu_mode[k];
                m_addr[k]  = d ? dma_addr[k]  : cpu_addr[k];
                m_wdata[k] = d ? dma_wdata[k] : cpu_wdata[k];
                if (d) e_dma_gnt[k] = 1'b1; else e_cpu_gnt[k] = 1'b1;
                m_age[k] = 1;
            end
        end else if (m_age[k] <= lat(k)) begin
            if (m_age[k] == lat(k)) begin
                if (m_owner_dma[k]) begin e_dma_rvalid[k] = 1'b1; e_dma_rdata[k] = ram_rdata[k]; end
                else                begin e_cpu_rvalid[k] = 1'b1; e_cpu_rdata[k] = ram_rdata[k]; end
            end
            m_age[k] = m_age[k] + 1;
        end else begin
            m_age[k] = 0;
        end
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    int vectors = 0;
    int errors  = 0;

    task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (lat%0d) t=%0t got %0h expected %0h", nm, lat(k), $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            bit in_ram;
            in_ram = (m_age[k] >= 1) && (m_age[k] <= lat(k));
            chk(k, "cpu_gnt",    32'(cpu_gnt[k]),    32'(e_cpu_gnt[k]));
            chk(k, "dma_gnt",    32'(dma_gnt[k]),    32'(e_dma_gnt[k]));
            chk(k, "cpu_rvalid", 32'(cpu_rvalid[k]), 32'(e_cpu_rvalid[k]));
            chk(k, "dma_rvalid", 32'(dma_rvalid[k]), 32'(e_dma_rvalid[k]));
            chk(k, "cpu_rdata",  cpu_rdata[k],       e_cpu_rdata[k]);
            chk(k, "dma_rdata",  dma_rdata[k],       e_dma_rdata[k]);
            chk(k, "ram_sel",    32'(ram_sel[k]),    in_ram ? 32'(m_mode[k]) : 32'd0);
            chk(k, "ram_addr",   ram_addr[k],        m_addr[k]);
            chk(k, "ram_wdata",  ram_wdata[k],       m_wdata[k]);
            chk(k, "busy",       32'(busy[k]),       32'(m_age[k] != 0));
            chk(k, "cpu_stall",  32'(cpu_stall[k]),  32'(cpu_req[k] & ~e_cpu_rvalid[k]));
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            cpu_req[k] = 0; cpu_mode[k] = '0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
            dma_req[k] = 0; dma_mode[k] = '0; dma_addr[k] = '0; dma_wdata[k] = '0;
            ram_rdata[k] = '0;
        end
    endtask

    task automatic do_reset();
        rst[0] = 1; rst[1] = 1;
        clear_inputs();
        step(); step();
        rst[0] = 0; rst[1] = 0;
    endtask

    initial begin
        int gseq[$];
        int sel_cnt, busy_cnt, rv_at, rv_seen;
        bit done;

        rst[0] = 1; rst[1] = 1;
        clear_inputs();
        step();
        chk(0, "reset_busy", 32'(busy[0]), 32'd0);
        chk(1, "reset_sel", 32'(ram_sel[1]), 32'd0);
        do_reset();

        // T1: single CPU read at LATENCY 1
        cpu_req[0] = 1; cpu_mode[0] = 4'h1; cpu_addr[0] = 32'h10; ram_rdata[0] = 32'hDEADBEEF;
        step();
        chk(0, "t1_gnt", 32'(cpu_gnt[0]), 32'd1);
        chk(0, "t1_sel", 32'(ram_sel[0]), 32'd1);
        chk(0, "t1_addr", ram_addr[0], 32'h10);
        chk(0, "t1_stall_busy", 32'(cpu_stall[0]), 32'd1);
        step();
        chk(0, "t1_rvalid", 32'(cpu_rvalid[0]), 32'd1);
        chk(0, "t1_rdata", cpu_rdata[0], 32'hDEADBEEF);
        chk(0, "t1_stall_done", 32'(cpu_stall[0]), 32'd0);
        cpu_req[0] = 0;
        step();

        // T2: both request at once; CPU first, DMA three cycles later
        do_reset();
        cpu_req[0] = 1; cpu_mode[0] = 4'h1; cpu_addr[0] = 32'h20;
        dma_req[0] = 1; dma_mode[0] = 4'h2; dma_addr[0] = 32'h30;
        ram_rdata[0] = 32'h0000_00A1;
        step();
        chk(0, "t2_cpu_gnt", 32'(cpu_gnt[0]), 32'd1);
        chk(0, "t2_dma_nogt", 32'(dma_gnt[0]), 32'd0);
        cpu_req[0] = 0;
        step(); step();
        ram_rdata[0] = 32'h0000_00B2;
        step();
        chk(0, "t2_dma_gnt", 32'(dma_gnt[0]), 32'd1);
        dma_req[0] = 0;
        step();
        chk(0, "t2_dma_rvalid", 32'(dma_rvalid[0]), 32'd1);
        chk(0, "t2_dma_rdata", dma_rdata[0], 32'h0000_00B2);
        chk(0, "t2_cpu_rdata", cpu_rdata[0], 32'h0000_00A1);
        step();

        // T3: both held continuously; grant order depends on the tie-break build
        do_reset();
        cpu_req[0] = 1; cpu_mode[0] = 4'h1; dma_req[0] = 1; dma_mode[0] = 4'h2;
        for (int c = 0; c < 40 && gseq.size() < 4; c++) begin
            step();
            if (cpu_gnt[0]) gseq.push_back(0);
            if (dma_gnt[0]) gseq.push_back(1);
        end
        chk(0, "t3_grants", 32'(gseq.size()), 32'd4);
        for (int i = 0; i < gseq.size(); i++)
            chk(0, "t3_order", 32'(gseq[i]), RR ? 32'(i % 2) : 32'd0);

        // T4: DMA write at LATENCY 3
        do_reset();
        dma_req[1] = 1; dma_mode[1] = 4'h8; dma_addr[1] = 32'h40; dma_wdata[1] = 32'h12345678;
        sel_cnt = 0; busy_cnt = 0; rv_at = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) begin
                chk(1, "t4_gnt", 32'(dma_gnt[1]), 32'd1);
                chk(1, "t4_wdata", ram_wdata[1], 32'h12345678);
                dma_req[1] = 0;
            end
            if (ram_sel[1] == 4'h8) sel_cnt++;
            if (busy[1]) busy_cnt++;
            if (dma_rvalid[1]) rv_at = c;
        end
        chk(1, "t4_sel_cycles", 32'(sel_cnt), 32'd3);
        chk(1, "t4_busy_cycles", 32'(busy_cnt), 32'd4);
        chk(1, "t4_rvalid_at", 32'(rv_at), 32'd4);

        // T5: reset in the second RAM cycle drops the transaction
        do_reset();
        cpu_req[1] = 1; cpu_mode[1] = 4'h1; cpu_addr[1] = 32'h50;
        step();
        chk(1, "t5_gnt", 32'(cpu_gnt[1]), 32'd1);
        cpu_req[1] = 0;
        step();
        chk(1, "t5_busy2", 32'(busy[1]), 32'd1);
        rst[1] = 1;
        step();
        chk(1, "t5_sel_after_rst", 32'(ram_sel[1]), 32'd0);
        chk(1, "t5_busy_after_rst", 32'(busy[1]), 32'd0);
        rst[1] = 0;
        rv_seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (cpu_rvalid[1]) rv_seen++;
        end
        chk(1, "t5_no_rvalid", 32'(rv_seen), 32'd0);
        cpu_req[1] = 1; cpu_mode[1] = 4'h2; cpu_addr[1] = 32'h54; ram_rdata[1] = 32'h55AA55AA;
        done = 0;
        for (int c = 0; c < 12 && !done; c++) begin
            step();
            if (cpu_gnt[1]) cpu_req[1] = 0;
            if (cpu_rvalid[1]) begin
                done = 1;
                chk(1, "t5_new_rdata", cpu_rdata[1], 32'h55AA55AA);
            end
        end
        chk(1, "t5_new_done", 32'(done), 32'd1);

        // T6: request with mode 0 is ignored until the mode becomes nonzero
        do_reset();
        cpu_req[0] = 1; cpu_mode[0] = 4'h0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk(0, "t6_nogt", 32'(cpu_gnt[0]), 32'd0);
            chk(0, "t6_sel0", 32'(ram_sel[0]), 32'd0);
            chk(0, "t6_stall", 32'(cpu_stall[0]), 32'd1);
        end
        cpu_mode[0] = 4'h3; cpu_addr[0] = 32'h60; ram_rdata[0] = 32'h0BADF00D;
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            step();
            if (cpu_rvalid[0]) begin
                done = 1;
                chk(0, "t6_stall_end", 32'(cpu_stall[0]), 32'd0);
                chk(0, "t6_rdata", cpu_rdata[0], 32'h0BADF00D);
            end else begin
                chk(0, "t6_stall_wait", 32'(cpu_stall[0]), 32'd1);
            end
        end
        chk(0, "t6_done", 32'(done), 32'd1);
        cpu_req[0] = 0;

        // Random traffic: requests held until granted, fields may wander, rare resets
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                rst[k] = ($urandom_range(0, 99) == 0);
                ram_rdata[k] = $urandom;
                if (cpu_req[k] && !e_cpu_gnt[k]) begin
                    if ($urandom_range(0, 7) == 0) cpu_mode[k] = 4'($urandom_range(0, 15));
                end else begin
                    cpu_req[k]   = ($urandom_range(0, 2) == 0);
                    cpu_mode[k]  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    cpu_addr[k]  = $urandom;
                    cpu_wdata[k] = $urandom;
                end
                if (dma_req[k] && !e_dma_gnt[k]) begin
                    if ($urandom_range(0, 7) == 0) dma_mode[k] = 4'($urandom_range(0, 15));
                end else begin
                    dma_req[k]   = ($urandom_range(0, 2) == 0);
                    dma_mode[k]  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    dma_addr[k]  = $urandom;
                    dma_wdata[k] = $urandom;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
